// File: rtl/swi_debouncer.sv
// swi_debouncer: synchroniser and debouncer for the slide-switch bus.
// Produces per-bit rise/fall pulses and a sticky event word that is drained
// by a valid/ack handshake.
// Build option: define SWI_DEBOUNCE_EN to enable the per-bit debounce
// counters. Without it, swi_stable follows the synchronised input directly.
module swi_debouncer #(
  parameter int NBITS           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic [NBITS-1:0] swi_raw,
  output logic [NBITS-1:0] swi_stable,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic             evt_valid,
  output logic [NBITS-1:0] evt_bits,
  input  logic             evt_ack
);

  logic [NBITS-1:0] r_sync [SYNC_STAGES];
  logic [NBITS-1:0] w_sync;
  logic [NBITS-1:0] w_stable_next;
  logic [NBITS-1:0] w_rise_next;
  logic [NBITS-1:0] w_fall_next;
  logic [NBITS-1:0] w_evt_next;
  logic             w_ack_taken;

  // Multi-flop synchroniser for the asynchronous switch levels
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= swi_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef SWI_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt [NBITS];

  // Accept a new level once the mismatch has persisted for DEBOUNCE_CYCLES edges
  always_comb begin
    w_stable_next = swi_stable;
    for (int unsigned b = 0; b < NBITS; b++) begin
      if ((w_sync[b] != swi_stable[b]) && (r_cnt[b] == LAST)) begin
        w_stable_next[b] = w_sync[b];
      end
    end
  end

  // Per-bit mismatch counters; any return to agreement discards the count
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NBITS; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NBITS; b++) begin
        if (w_sync[b] == swi_stable[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == LAST) begin
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
    end
  end
`else
  // No filtering: the debounced level is the synchronised level one edge later
  always_comb begin
    w_stable_next = w_sync;
  end
`endif

  // Edge detection and event accumulation; flips on the ack edge are retained
  always_comb begin
    w_rise_next = w_stable_next & ~swi_stable;
    w_fall_next = ~w_stable_next & swi_stable;
    w_ack_taken = evt_valid & evt_ack;
    w_evt_next  = (w_ack_taken ? '0 : evt_bits) | w_rise_next | w_fall_next;
  end

  // Registered outputs
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      swi_stable <= '0;
      rise       <= '0;
      fall       <= '0;
      evt_bits   <= '0;
      evt_valid  <= 1'b0;
    end else begin
      swi_stable <= w_stable_next;
      rise       <= w_rise_next;
      fall       <= w_fall_next;
      evt_bits   <= w_evt_next;
      evt_valid  <= |w_evt_next;
    end
  end

endmodule

// File: tb/tb_swi_debouncer.sv
// Self-checking bench for swi_debouncer: reference model plus literal checks.
module tb_swi_debouncer;
  localparam int NB = 8;
  localparam int S  = 2;
  localparam int DC = 4;
`ifdef SWI_DEBOUNCE_EN
  localparam int D = DC;
`else
  localparam int D = 1;
`endif
  localparam int L = S + D;

  logic          clk_2 = 1'b0;
  logic          rst_n;
  logic          evt_ack = 1'b0;
  logic [NB-1:0] swi_raw = '0;
  logic [NB-1:0] swi_stable, rise, fall, evt_bits;
  logic          evt_valid;

  swi_debouncer #(.NBITS(NB), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_2(clk_2), .rst_n(rst_n), .swi_raw(swi_raw), .swi_stable(swi_stable),
    .rise(rise), .fall(fall), .evt_valid(evt_valid), .evt_bits(evt_bits),
    .evt_ack(evt_ack)
  );

  always #5 clk_2 = ~clk_2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the level seen at edge n is the raw value sampled S edges
  // earlier; a bit flips once its last D pre-edge samples all disagree with it.
  logic [NB-1:0] m_samp [S];
  logic [NB-1:0] m_win  [D];
  logic [NB-1:0] m_stable = '0, m_rise = '0, m_fall = '0, m_evt = '0;
  logic          m_valid = 1'b0;

  initial begin
    for (int k = 0; k < S; k++) m_samp[k] = '0;
    for (int k = 0; k < D; k++) m_win[k] = '0;
  end

  always @(posedge clk_2 or negedge rst_n) begin : model
    logic [NB-1:0] pre, flip;
    logic          ack_taken;
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m_samp[k] = '0;
      for (int k = 0; k < D; k++) m_win[k] = '0;
      m_stable = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_valid = 1'b0;
    end else begin
      pre = m_samp[S-1];
      for (int k = S-1; k > 0; k--) m_samp[k] = m_samp[k-1];
      m_samp[0] = swi_raw;
      for (int k = D-1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = pre;
      flip = '1;
      for (int k = 0; k < D; k++) flip = flip & (m_win[k] ^ m_stable);
      m_rise    = flip & ~m_stable;
      m_fall    = flip & m_stable;
      ack_taken = m_valid & evt_ack;
      m_evt     = (ack_taken ? '0 : m_evt) | flip;
      m_valid   = |m_evt;
      m_stable  = m_stable ^ flip;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk_2) begin
    chk("m_stable", swi_stable, m_stable);
    chk("m_rise",   rise,       m_rise);
    chk("m_fall",   fall,       m_fall);
    chk("m_evt",    evt_bits,   m_evt);
    chk("m_valid",  evt_valid,  m_valid);
    chk("m_rf_excl", rise & fall, 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic clear_evt();
    @(negedge clk_2) evt_ack = 1'b1;
    @(negedge clk_2) evt_ack = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_stable"}, swi_stable, 0);
    chk({nm, "_rise"},   rise,       0);
    chk({nm, "_fall"},   fall,       0);
    chk({nm, "_evt"},    evt_bits,   0);
    chk({nm, "_valid"},  evt_valid,  0);
  endtask

  initial begin
    // 1: reset with all switches high, then release
    rst_n   = 1'b1;
    swi_raw = 8'hFF;
    #1 rst_n = 1'b0;
    #2 chk_zero("rst_async");
    settle(3);
    chk_zero("rst_held");
    #2 rst_n = 1'b1;
    tick(L-1);
    chk("t1_pre", swi_stable, 8'h00);
    tick(1);
    chk("t1_stable", swi_stable, 8'hFF);
    chk("t1_rise",   rise,       8'hFF);
    chk("t1_evt",    evt_bits,   8'hFF);
    chk("t1_valid",  evt_valid,  1);
    tick(1);
    chk("t1_rise_end", rise, 8'h00);
    @(negedge clk_2) evt_ack = 1'b1;
    tick(1);
    chk("t1_ack_valid", evt_valid, 0);
    chk("t1_ack_evt",   evt_bits,  8'h00);
    @(negedge clk_2) evt_ack = 1'b0;

    @(negedge clk_2) swi_raw = 8'h00;
    settle(L+4);
    clear_evt();
    settle(2);

`ifdef SWI_DEBOUNCE_EN
    // 2: 3-cycle glitch on bit 0 is filtered
    @(negedge clk_2) swi_raw = 8'h01;
    settle(3);
    swi_raw = 8'h00;
    settle(L+5);
    chk("t2_stable", swi_stable, 8'h00);
    chk("t2_valid",  evt_valid,  0);
    chk("t2_evt",    evt_bits,   8'h00);
`else
    // 6: 1-cycle glitch on bit 1 propagates
    @(negedge clk_2) swi_raw = 8'h02;
    @(negedge clk_2) swi_raw = 8'h00;
    tick(2);
    chk("t6_stable_hi", swi_stable, 8'h02);
    chk("t6_rise",      rise,       8'h02);
    tick(1);
    chk("t6_stable_lo", swi_stable, 8'h00);
    chk("t6_fall",      fall,       8'h02);
    chk("t6_rise_lo",   rise,       8'h00);
    chk("t6_evt",       evt_bits,   8'h02);
    clear_evt();
`endif

    // 3: bit 3 rises with bit 5 already high
    @(negedge clk_2) swi_raw = 8'h20;
    settle(L+3);
    clear_evt();
    settle(2);
    @(negedge clk_2) swi_raw = 8'h28;
    tick(L-1);
    chk("t3_pre", swi_stable, 8'h20);
    tick(1);
    chk("t3_stable", swi_stable, 8'h28);
    chk("t3_rise",   rise,       8'h08);
    tick(1);
    chk("t3_rise_end", rise,      8'h00);
    chk("t3_evt",      evt_bits,  8'h08);
    chk("t3_valid",    evt_valid, 1);

    // 4: ack on the edge where bit 5 falls keeps the new event
    @(negedge clk_2) swi_raw = 8'h08;
    repeat (L-1) @(posedge clk_2);
    @(negedge clk_2) evt_ack = 1'b1;
    tick(1);
    chk("t4_fall",   fall,       8'h20);
    chk("t4_evt",    evt_bits,   8'h20);
    chk("t4_valid",  evt_valid,  1);
    chk("t4_stable", swi_stable, 8'h08);
    @(negedge clk_2) evt_ack = 1'b0;

    // 5: async reset mid-count on bit 2, then the full latency again
    clear_evt();
    settle(2);
    @(negedge clk_2) swi_raw = 8'h0C;
    repeat (L-1) @(posedge clk_2);
    #3 rst_n = 1'b0;
    #1 chk_zero("t5_rst");
    @(negedge clk_2);
    #2 rst_n = 1'b1;
    tick(L-1);
    chk("t5_pre", swi_stable, 8'h00);
    tick(1);
    chk("t5_stable", swi_stable, 8'h0C);
    chk("t5_rise",   rise,       8'h0C);

    // Random phase, model checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_2);
      if ($urandom_range(0, 3) == 0) swi_raw = swi_raw ^ 8'($urandom & $urandom & $urandom);
      evt_ack = ($urandom_range(0, 2) == 0);
      if (i == 1500) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(negedge clk_2) evt_ack = 1'b0;
    settle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
